// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command/response bytes, scan-code and ASCII codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Set-2 make codes used by the receiver and key-state memory
  typedef enum logic [7:0] {
    SC_A      = 8'h1C,
    SC_SPACE  = 8'h29,
    SC_ENTER  = 8'h5A,
    SC_BKSP   = 8'h66,
    SC_ESC    = 8'h76,
    SC_EXT    = 8'hE0,
    SC_BREAK  = 8'hF0
  } ps2_scan_e;

  typedef enum logic [7:0] {
    ASCII_NUL   = 8'h00,
    ASCII_BS    = 8'h08,
    ASCII_LF    = 8'h0A,
    ASCII_ESC   = 8'h1B,
    ASCII_SPACE = 8'h20,
    ASCII_A     = 8'h41
  } ps2_ascii_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a registered falling-edge pulse on clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2ClkIn,
  input  logic ps2DataIn,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Idle bus is high, so reset to 1 to avoid a false fall when leaving reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_prev  <= 1'b1;
      clk_fall  <= 1'b0;
    end else begin
      clk_meta  <= ps2ClkIn;
      clk_sync  <= clk_meta;
      data_meta <= ps2DataIn;
      data_sync <= data_meta;
      clk_prev  <= clk_sync;
      clk_fall  <= clk_prev & ~clk_sync;
    end
  end

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter with inhibit/request sequencing, ACK check and edge timeout.
// state     | meaning
// IDLE      | bus released, waiting for txStart
// INHIBIT   | clock held low for INHIBIT_CYCLES
// REQUEST   | clock and data both low (start bit) for one cycle
// SHIFT     | device clocking out data, parity, stop
// ACK       | waiting for 11th fall to sample device ACK
// WAIT_IDLE | waiting for clock and data both high
// DONE      | txDone pulse
// ERROR     | txError pulse, lines released
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txByte,
  input  logic       txStart,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow,
  output logic       busy,
  output logic       rxInhibit,
  output logic       txDone,
  output logic       txError
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             clk_drv_q, clk_drv_d;
  logic             data_drv_q, data_drv_d;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;
  logic timeout;

  ps2_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2ClkIn  (ps2ClkIn),
    .ps2DataIn (ps2DataIn),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      timer_q    <= '0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      timer_q    <= timer_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
    end
  end

  assign timeout = (timer_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    // Saturating edge timer; every device clock fall restarts it
    if (clk_fall)
      timer_d = '0;
    else if (timer_q != '1)
      timer_d = timer_q + TMO_W'(1);
    else
      timer_d = timer_q;

    case (state_q)
      IDLE: begin
        if (txStart) begin
          frame_d    = {1'b1, odd_parity(txByte), txByte};
          clk_drv_d  = 1'b1;
          data_drv_d = 1'b0;
          inh_cnt_d  = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_LAST) begin
          data_drv_d = 1'b1;
          timer_d    = '0;
          state_d    = REQUEST;
        end
      end
      REQUEST: begin
        if (timeout) begin
          state_d = ERROR;
        end else begin
          clk_drv_d = 1'b0;
          bit_cnt_d = '0;
          timer_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          data_drv_d = ~frame_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9)
            state_d = ACK;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      ACK: begin
        if (clk_fall)
          state_d = data_sync ? ERROR : WAIT_IDLE;
        else if (timeout)
          state_d = ERROR;
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync)
          state_d = DONE;
        else if (timeout)
          state_d = ERROR;
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == ERROR) begin
      clk_drv_d  = 1'b0;
      data_drv_d = 1'b0;
    end
  end

  assign ps2ClkDriveLow  = clk_drv_q;
  assign ps2DataDriveLow = data_drv_q;
  assign busy            = (state_q != IDLE);
  assign rxInhibit       = busy;
  assign txDone          = (state_q == DONE);
  assign txError         = (state_q == ERROR);

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a behavioural PS/2 device model clocks frames and ACKs or withholds them.
module tb_ps2_host_transmitter;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txByte = 8'h00;
  logic       txStart = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2ClkIn, ps2DataIn;
  logic       ps2ClkDriveLow, ps2DataDriveLow;
  logic       busy, rxInhibit, txDone, txError;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_err_lines = 0;
  int n_inh_bad = 0;

  // Open-drain bus: either side can pull a line low
  assign ps2ClkIn  = dev_clk & ~ps2ClkDriveLow;
  assign ps2DataIn = dev_data & ~ps2DataDriveLow;

  always #5 clk = ~clk;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .txByte          (txByte),
    .txStart         (txStart),
    .ps2ClkIn        (ps2ClkIn),
    .ps2DataIn       (ps2DataIn),
    .ps2ClkDriveLow  (ps2ClkDriveLow),
    .ps2DataDriveLow (ps2DataDriveLow),
    .busy            (busy),
    .rxInhibit       (rxInhibit),
    .txDone          (txDone),
    .txError         (txError)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (txDone === 1'b1) n_done <= n_done + 1;
      if (txError === 1'b1) n_err <= n_err + 1;
      if (txError === 1'b1 && (ps2ClkDriveLow !== 1'b0 || ps2DataDriveLow !== 1'b0))
        n_err_lines <= n_err_lines + 1;
      if (busy !== rxInhibit) n_inh_bad <= n_inh_bad + 1;
    end
  end

  // Expected 11-bit frame as seen by the device, index 0 = start bit
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    txByte  = b;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
  endtask

  // Device side: waits for the host request, then generates nclk clock pulses sampling data on rises
  task automatic dev_xfer(input int nclk, input bit ack, output logic [10:0] cap,
                          output int low_cyc, output bit ok);
    int guard;
    cap = '1;
    low_cyc = 0;
    ok = 1'b1;
    guard = 0;
    while (ps2ClkDriveLow !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      ok = 1'b0;
      return;
    end
    guard = 0;
    while (ps2ClkDriveLow === 1'b1 && guard < 2000) begin
      @(negedge clk);
      low_cyc++;
      guard++;
    end
    if (guard >= 2000) begin
      ok = 1'b0;
      return;
    end
    cap[0] = ps2DataIn;
    for (int i = 1; i <= nclk; i++) begin
      repeat (5) @(negedge clk);
      if (i == 11 && ack) dev_data = 1'b0;
      repeat (HALF - 5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) cap[i] = ps2DataIn;
    end
    if (nclk == 11) begin
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ps2ClkDriveLow, ps2DataDriveLow, busy, rxInhibit, txDone, txError} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {ps2ClkDriveLow, ps2DataDriveLow, busy, rxInhibit, txDone, txError});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ps2ClkDriveLow !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b clkdrv=%b want 0 0", busy, ps2ClkDriveLow);
    end
  endtask

  task automatic test_frame(input logic [7:0] b);
    logic [10:0] cap, exp;
    int low, d0, e0, guard;
    bit ok;
    d0 = n_done;
    e0 = n_err;
    start_tx(b);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_accept %h: got %b want 1", b, busy);
    end
    dev_xfer(11, 1'b1, cap, low, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL handshake %h: got %b want 1", b, ok);
    end
    total++;
    if (low < INH) begin
      bad++;
      $display("FAIL inhibit_len %h: got %0d want >=%0d", b, low, INH);
    end
    exp = ref_frame(b);
    total++;
    if (cap !== exp) begin
      bad++;
      $display("FAIL frame %h: got %b want %b", b, cap, exp);
    end
    guard = 0;
    while (txDone !== 1'b1 && txError !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    total++;
    if (n_done - d0 != 1 || n_err - e0 != 0) begin
      bad++;
      $display("FAIL result %h: done=%0d err=%0d want 1 0", b, n_done - d0, n_err - e0);
    end
    total++;
    if (busy !== 1'b0 || ps2ClkDriveLow !== 1'b0 || ps2DataDriveLow !== 1'b0) begin
      bad++;
      $display("FAIL idle_after %h: busy=%b clk=%b data=%b want 0 0 0",
               b, busy, ps2ClkDriveLow, ps2DataDriveLow);
    end
  endtask

  task automatic test_timeout();
    int guard, cyc, d0;
    d0 = n_done;
    start_tx(8'($urandom));
    guard = 0;
    while (ps2ClkDriveLow === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    cyc = 0;
    while (txError !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc < TMO - 5 || cyc > TMO + 5) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d want about %0d", cyc, TMO);
    end
    total++;
    if (ps2ClkDriveLow !== 1'b0 || ps2DataDriveLow !== 1'b0) begin
      bad++;
      $display("FAIL timeout_release: clk=%b data=%b want 0 0", ps2ClkDriveLow, ps2DataDriveLow);
    end
    @(negedge clk);
    #1;
    total++;
    if (n_done != d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_no_done: done=%0d busy=%b want 0 0", n_done - d0, busy);
    end
  endtask

  task automatic test_no_ack();
    logic [7:0] b;
    logic [10:0] cap;
    int low, d0, e0;
    bit ok;
    b = 8'($urandom);
    d0 = n_done;
    e0 = n_err;
    start_tx(b);
    dev_xfer(11, 1'b0, cap, low, ok);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (cap !== ref_frame(b)) begin
      bad++;
      $display("FAIL noack_frame %h: got %b want %b", b, cap, ref_frame(b));
    end
    total++;
    if (n_err - e0 != 1 || n_done - d0 != 0) begin
      bad++;
      $display("FAIL noack_result: err=%0d done=%0d want 1 0", n_err - e0, n_done - d0);
    end
    total++;
    if (busy !== 1'b0 || ps2ClkDriveLow !== 1'b0 || ps2DataDriveLow !== 1'b0) begin
      bad++;
      $display("FAIL noack_idle: busy=%b clk=%b data=%b want 0 0 0",
               busy, ps2ClkDriveLow, ps2DataDriveLow);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [10:0] cap;
    int low, d0, e0;
    bit ok;
    b = 8'($urandom) & 8'hF7;  // bit 3 zero: host is holding data low when reset hits
    d0 = n_done;
    e0 = n_err;
    start_tx(b);
    dev_xfer(4, 1'b0, cap, low, ok);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || ps2DataDriveLow !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: busy=%b data=%b want 1 1", busy, ps2DataDriveLow);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ps2ClkDriveLow !== 1'b0 || ps2DataDriveLow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_release: clk=%b data=%b busy=%b want 0 0 0",
               ps2ClkDriveLow, ps2DataDriveLow, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    total++;
    if (n_done != d0 || n_err != e0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_retry: done=%0d err=%0d busy=%b want 0 0 0",
               n_done - d0, n_err - e0, busy);
    end
    test_frame(8'($urandom));
  endtask

  task automatic test_busy_ignore();
    logic [7:0] a, c;
    logic [10:0] cap;
    int low, guard;
    bit ok;
    a = 8'($urandom);
    c = ~a;
    start_tx(a);
    repeat (5) @(negedge clk);
    txByte  = c;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    dev_xfer(11, 1'b1, cap, low, ok);
    total++;
    if (cap !== ref_frame(a)) begin
      bad++;
      $display("FAIL busy_ignore_frame: got %b want %b", cap, ref_frame(a));
    end
    guard = 0;
    while (txDone !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (txDone !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: done=%b busy=%b want 1 1", txDone, busy);
    end
    // Request arriving on the DONE cycle must be dropped
    txByte  = c;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ps2ClkDriveLow !== 1'b0) begin
      bad++;
      $display("FAIL start_on_done: busy=%b clk=%b want 0 0", busy, ps2ClkDriveLow);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame(8'hED);
    test_frame(8'hF4);
    test_frame(8'h00);
    test_frame(8'hFF);
    for (int k = 0; k < 4; k++) test_frame(8'($urandom));
    test_timeout();
    test_no_ack();
    test_reset_mid();
    test_busy_ignore();
    total++;
    if (n_err_lines != 0 || n_inh_bad != 0) begin
      bad++;
      $display("FAIL monitors: err_lines=%0d inhibit_mismatch=%0d want 0 0", n_err_lines, n_inh_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
